// File: rtl/ir_fetch_assembler.sv
// ir_fetch_assembler
//   Instruction register that assembles variable-length instructions from a
//   stream of DATA_W-bit units. It holds the finished instruction until the
//   control unit consumes it.
//   The length comes from the top LEN_W bits of the first unit:
//   total units = extra + 1.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   flush        synchronous abort of a partial or held instruction
//   byte_in      instruction unit from memory
//   byte_valid   byte_in is valid
//   byte_ready   unit accepted this cycle (combinational)
//   instr_out    assembled instruction, unit k at [k*DATA_W +: DATA_W]
//   instr_len    extra units beyond the first
//   instr_valid  instruction complete (state FULL)
//   instr_ready  control unit consumes the instruction
//   busy         partial instruction in progress (state COLLECT)

// One unit slot of the instruction register. load wins over clr, so slot 0
// can take the new first unit while the other slots clear.
module ir_unit_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q <= '0;
    else if (load) q <= d;
    else if (clr)  q <= '0;
  end
endmodule

module ir_fetch_assembler #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [DATA_W-1:0]           byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic [MAX_BYTES*DATA_W-1:0] instr_out,
  output logic [LEN_W-1:0]            instr_len,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic                        busy
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t                             state, state_n;
  logic [LEN_W-1:0]                   count, count_n;
  logic [LEN_W-1:0]                   len_n;
  logic [LEN_W-1:0]                   extra;
  logic                               accept;
  logic                               clr_all;
  logic [MAX_BYTES-1:0]               load_vec;
  logic [MAX_BYTES-1:0][DATA_W-1:0]   units;

  assign extra = byte_in[DATA_W-1 -: LEN_W];

  // Gated by reset so nothing looks accepted while reset is asserted.
  assign byte_ready  = reset & (state != FULL) & ~flush;
  assign accept      = byte_valid & byte_ready;
  assign instr_valid = (state == FULL);
  assign busy        = (state == COLLECT);
  assign instr_out   = units;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      count     <= '0;
      instr_len <= '0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      instr_len <= len_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    len_n    = instr_len;
    clr_all  = 1'b0;
    load_vec = '0;
    if (flush) begin
      // Abort wins over every handshake. The register contents are kept.
      state_n = EMPTY;
      count_n = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            clr_all     = 1'b1;
            load_vec[0] = 1'b1;
            len_n       = extra;
            count_n     = LEN_W'(1);
            state_n     = (extra == '0) ? FULL : COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            load_vec[count] = 1'b1;
            // The last unit lands at index instr_len. Parking count at 0
            // keeps it from ever reaching MAX_BYTES.
            if (count == instr_len) begin
              state_n = FULL;
              count_n = '0;
            end else begin
              count_n = count + LEN_W'(1);
            end
          end
        end
        FULL: begin
          if (instr_ready) state_n = EMPTY;
        end
        default: begin
          state_n = EMPTY;
          count_n = '0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < MAX_BYTES; k++) begin : g_unit
    ir_unit_reg #(.DATA_W(DATA_W)) u_unit (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_all),
      .load  (load_vec[k]),
      .d     (byte_in),
      .q     (units[k])
    );
  end

endmodule

// File: tb/tb_ir_fetch_assembler.sv
module tb_ir_fetch_assembler;
  localparam int DATA_W    = 8;
  localparam int MAX_BYTES = 4;
  localparam int LEN_W     = 2;
  localparam int OW        = MAX_BYTES * DATA_W;

  logic              clk = 0;
  logic              reset = 0;
  logic              flush = 0;
  logic [DATA_W-1:0] byte_in = '0;
  logic              byte_valid = 0;
  logic              byte_ready;
  logic [OW-1:0]     instr_out;
  logic [LEN_W-1:0]  instr_len;
  logic              instr_valid;
  logic              instr_ready = 0;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit run = 0;

  ir_fetch_assembler #(.DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .instr_out(instr_out),
    .instr_len(instr_len), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes gathered so far, how many are needed,
  // and whether a finished instruction is being held.
  logic [DATA_W-1:0] part[$];
  int                need;
  bit                held;
  logic [OW-1:0]     m_out;
  logic [LEN_W-1:0]  m_len;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      part.delete(); need = 0; held = 0; m_out = '0; m_len = '0;
    end else if (flush) begin
      part.delete(); held = 0;
    end else if (held) begin
      if (instr_ready) held = 0;
    end else if (byte_valid) begin
      if (part.size() == 0) begin
        m_len = byte_in[DATA_W-1 -: LEN_W];
        need  = int'(m_len) + 1;
        m_out = '0;
      end
      m_out[part.size()*DATA_W +: DATA_W] = byte_in;
      part.push_back(byte_in);
      if (part.size() == need) begin
        held = 1;
        part.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("byte_ready",  64'(byte_ready),  64'(reset && !held && !flush));
      chk("instr_valid", 64'(instr_valid), 64'(held));
      chk("busy",        64'(busy),        64'(part.size() != 0));
      chk("instr_out",   64'(instr_out),   64'(m_out));
      chk("instr_len",   64'(instr_len),   64'(m_len));
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask

  task automatic send(input logic [DATA_W-1:0] b);
    byte_valid = 1; byte_in = b; cyc(); byte_valid = 0;
  endtask

  task automatic consume();
    instr_ready = 1; cyc(); instr_ready = 0;
  endtask

  initial begin
    run = 1;
    reset = 0; cyc(); cyc();
    chk("rst_ready", 64'(byte_ready), 64'(0));
    chk("rst_out",   64'(instr_out),  64'(0));
    reset = 1; cyc();

    // single unit
    send(8'h15);
    chk("single_valid", 64'(instr_valid), 64'(1));
    chk("single_out",   64'(instr_out),   64'h15);
    chk("single_len",   64'(instr_len),   64'(0));
    chk("single_busy",  64'(busy),        64'(0));
    consume();
    chk("consume_valid", 64'(instr_valid), 64'(0));

    // four units
    send(8'hC1);
    chk("four_busy", 64'(busy), 64'(1));
    send(8'h22); send(8'h33); send(8'h44);
    chk("four_valid", 64'(instr_valid), 64'(1));
    chk("four_out",   64'(instr_out),   64'h443322C1);
    chk("four_len",   64'(instr_len),   64'(3));

    // back-pressure while FULL
    byte_valid = 1; byte_in = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      #0 chk("bp_ready", 64'(byte_ready), 64'(0));
      cyc();
      chk("bp_out", 64'(instr_out), 64'h443322C1);
    end
    instr_ready = 1; cyc(); instr_ready = 0;
    chk("bp_valid", 64'(instr_valid), 64'(0));
    cyc(); byte_valid = 0;
    chk("bp_take", 64'(instr_out), 64'h000000AA);
    chk("bp_busy", 64'(busy), 64'(1));
    flush = 1; cyc(); flush = 0;
    chk("fl_busy0", 64'(busy), 64'(0));

    // bubbles
    send(8'h47);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bub_busy", 64'(busy), 64'(1));
    end
    send(8'h99);
    chk("bub_out", 64'(instr_out), 64'h00009947);
    chk("bub_len", 64'(instr_len), 64'(1));
    consume();

    // flush mid-assembly
    send(8'hC1); send(8'h22);
    flush = 1; byte_valid = 1; byte_in = 8'h33; cyc();
    flush = 0; byte_valid = 0;
    chk("flush_busy",  64'(busy),        64'(0));
    chk("flush_valid", 64'(instr_valid), 64'(0));
    chk("flush_hold",  64'(instr_out),   64'h000022C1);
    send(8'h05);
    chk("after_flush_out", 64'(instr_out), 64'h00000005);
    chk("after_flush_len", 64'(instr_len), 64'(0));

    // async reset while FULL
    @(posedge clk); #2 reset = 0; #1;
    chk("arst_valid", 64'(instr_valid), 64'(0));
    chk("arst_out",   64'(instr_out),   64'(0));
    chk("arst_busy",  64'(busy),        64'(0));
    chk("arst_ready", 64'(byte_ready),  64'(0));
    cyc(); reset = 1; cyc();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      byte_valid  = ($urandom_range(0, 9) < 7);
      byte_in     = DATA_W'($urandom);
      instr_ready = $urandom_range(0, 1) == 1;
      flush       = ($urandom_range(0, 24) == 0);
      if (i % 700 == 350) begin
        #2 reset = 0; cyc(); reset = 1;
      end
      cyc();
    end
    byte_valid = 0; instr_ready = 0; flush = 0;
    cyc(); cyc();
    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ir_fetch_assembler.md
Name: ir_fetch_assembler

Overview:
Parametrised instruction register for the next-generation fetch path. It assembles variable-length instructions of 1..MAX_BYTES units, each DATA_W bits wide, from instruction memory. Units arrive over a valid/ready stream. The block then holds the complete instruction for the control unit, which consumes it over a second valid/ready handshake. It replaces the single-unit load-enable IR and adds length decode, multi-cycle assembly, back-pressure and flush.

Parameters:
DATA_W, 8, width of one instruction unit from memory
MAX_BYTES, 4, maximum units per instruction; power of two, >= 2
LEN_W, 2, length-field width; must equal clog2(MAX_BYTES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
flush  input  1  synchronous abort of any partial or held instruction
byte_in  input  DATA_W  instruction unit from memory
byte_valid  input  1  byte_in is valid
byte_ready  output  1  block accepts byte_in this cycle
instr_out  output  MAX_BYTES*DATA_W  assembled instruction; first unit in bits [DATA_W-1:0], unit k in bits [k*DATA_W +: DATA_W]
instr_len  output  LEN_W  extra units in instr_out (0 = single-unit instruction)
instr_valid  output  1  instr_out/instr_len complete and stable
instr_ready  input  1  control unit consumes instruction
busy  output  1  partial instruction in progress (state COLLECT)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=EMPTY, count=0.
  - instr_out=0, instr_len=0, instr_valid=0, busy=0.
  - byte_ready is 0 while reset is asserted.
- Length decode:
  - extra = byte_in[DATA_W-1 -: LEN_W] of the first unit.
  - Total units = extra+1, range 1..MAX_BYTES.
- Accept: a unit is taken on a rising edge with byte_valid=1 and byte_ready=1.
- byte_ready = (state != FULL) and not flush. It is combinational from state and flush.
- EMPTY:
  - On accept: instr_out cleared to 0 with unit 0 = byte_in; instr_len=extra; count=1.
  - If extra=0, go to FULL. Otherwise go to COLLECT.
- COLLECT:
  - On accept: unit[count]=byte_in; count=count+1.
  - If count+1 == instr_len+1, go to FULL.
  - With no byte_valid, hold all state. Bubbles of any length are allowed.
- FULL:
  - instr_valid=1; byte_ready=0; instr_out and instr_len stable.
  - On instr_ready=1, go to EMPTY next edge; instr_valid=0 from that edge.
  - instr_out holds its last value in EMPTY until the next first unit is accepted.
  - No unit is accepted in the consume cycle (one-cycle turnaround).
- Latency:
  - Single-unit instruction accepted at edge N gives instr_valid=1 after edge N.
  - An n-unit instruction is valid after the edge accepting unit n-1.
- busy = (state == COLLECT). Registered via state.
- flush=1 (synchronous, highest priority):
  - Next state EMPTY, count=0, instr_valid=0.
  - instr_out and instr_len hold.
  - Any byte or instr_ready handshake in the same cycle is ignored.
- Reset mid-assembly: immediate return to the reset values above; partial units are discarded.
- instr_ready while instr_valid=0 has no effect.
- byte_in is ignored while byte_valid=0.
- count never exceeds MAX_BYTES-1. No wrap-around is possible because the length field bounds it.

Test Plan:
- Reset then single unit: reset=0 for 2 cycles, release; feed 8'h15 (extra=0) -> instr_valid=1 next cycle, instr_out=32'h00000015, instr_len=0, busy never 1.
- Four-unit instruction: feed C1,22,33,44 on consecutive cycles -> busy=1 after first edge; instr_valid=1 after fourth edge; instr_out=32'h443322C1, instr_len=3.
- Back-pressure: hold instr_ready=0 for 5 cycles in FULL while byte_valid=1 with 8'hAA -> byte_ready=0 throughout, instr_out unchanged. Raise instr_ready -> instr_valid=0 next cycle; 8'hAA accepted the cycle after.
- Bubbles: two-unit 8'h47, gap 3 cycles, 8'h99 -> state held in COLLECT during gap; final instr_out=32'h00009947, instr_len=1.
- Flush mid-assembly: C1,22 accepted, then flush=1 with byte_valid=1 on 8'h33 -> 8'h33 dropped, busy=0, instr_valid=0. Next 8'h05 gives instr_out=32'h00000005 (upper units cleared).
- Async reset in FULL: assert reset between clock edges while instr_valid=1 -> instr_valid, instr_out, busy go to 0 immediately, without waiting for a clk edge.
